// File: rtl/pipe_regfile.sv
// Register file fused with the ID/EX operand registers: registered reads that honour
// stall/flush, optional write-back bypass into captured operands, and a debug read port.
module pipe_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       stall,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [ADDR_W-1:0]          dbg_addr,
  output logic [DATA_W-1:0]          dbg_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dbg_data;
  logic              w_wr_ok;
  logic              w_dbg_zero;

  // Entry 0 is hard-wired when ZERO_REG is set, so its writes never commit or bypass.
  assign w_wr_ok    = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  assign w_dbg_zero = (ZERO_REG != 0) && (dbg_addr == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dbg_data <= '0;
    end else begin
      r_dbg_data <= w_dbg_zero ? '0 : r_mem[dbg_addr];
    end
  end

  assign dbg_data = r_dbg_data;

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_port
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_cap_val;
      logic              w_fwd;
      logic              w_refresh;
      logic [ADDR_W-1:0] r_cap_addr;
      logic [DATA_W-1:0] r_data;

      assign w_addr    = rd_addr[gi*ADDR_W +: ADDR_W];
      assign w_fwd     = (BYPASS != 0) && w_wr_ok && (wr_addr == w_addr);
      // While stalled, a write to the held operand's register keeps it current.
      assign w_refresh = (BYPASS != 0) && w_wr_ok && (wr_addr == r_cap_addr);

      always_comb begin
        w_cap_val = r_mem[w_addr];
        if ((ZERO_REG != 0) && (w_addr == '0)) begin
          w_cap_val = '0;
        end else if (w_fwd) begin
          w_cap_val = wr_data;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_cap_addr <= '0;
          r_data     <= '0;
        end else if (flush) begin
          r_cap_addr <= '0;
          r_data     <= '0;
        end else if (stall) begin
          if (w_refresh) begin
            r_data <= wr_data;
          end
        end else begin
          r_cap_addr <= w_addr;
          r_data     <= w_cap_val;
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = r_data;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_regfile.sv
// Directed bench: three pipe_regfile variants (default, ZERO_REG=0, BYPASS=0) share stimulus.
module tb_pipe_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic        stall, flush, wr_en;
  logic [4:0]  wr_addr, dbg_addr;
  logic [31:0] wr_data;

  logic [63:0] rd_a, rd_z, rd_b;
  logic [31:0] dbg_a, dbg_z, dbg_b;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_regfile u_dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_a),
    .stall(stall), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_a)
  );

  pipe_regfile #(.ZERO_REG(0)) u_nz (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_z),
    .stall(stall), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_z)
  );

  pipe_regfile #(.BYPASS(0)) u_nb (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_b),
    .stall(stall), .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .dbg_addr(dbg_addr), .dbg_data(dbg_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  initial begin
    rst_n = 1'b0; rd_addr = '0; stall = 1'b0; flush = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;

    // Reset
    tick(); tick();
    chk("rst_rd0", rd_a[31:0], 32'h0);
    chk("rst_rd1", rd_a[63:32], 32'h0);
    chk("rst_dbg", dbg_a, 32'h0);
    chk("rst_nb_rd0", rd_b[31:0], 32'h0);

    // Write r5 then read it
    rst_n = 1'b1;
    wr(5'd5, 32'hDEADBEEF); tick();
    wr_en = 1'b0; rd_addr[4:0] = 5'd5; tick();
    chk("rd_r5", rd_a[31:0], 32'hDEADBEEF);
    chk("rd_r5_nb", rd_b[31:0], 32'hDEADBEEF);

    // Zero register
    wr(5'd0, 32'h12345678); tick();
    wr_en = 1'b0; rd_addr[9:5] = 5'd0; dbg_addr = 5'd0; tick();
    chk("zero_rd1", rd_a[63:32], 32'h0);
    chk("zero_dbg", dbg_a, 32'h0);
    chk("nz_rd1", rd_z[63:32], 32'h12345678);
    chk("nz_dbg", dbg_z, 32'h12345678);

    // Same-edge bypass
    wr(5'd7, 32'h1); tick();
    wr(5'd7, 32'hA5A5A5A5); rd_addr = {5'd7, 5'd7}; tick();
    chk("byp_rd0", rd_a[31:0], 32'hA5A5A5A5);
    chk("byp_rd1", rd_a[63:32], 32'hA5A5A5A5);
    chk("nb_old_rd0", rd_b[31:0], 32'h1);
    chk("nb_old_rd1", rd_b[63:32], 32'h1);
    wr_en = 1'b0; tick();
    chk("nb_new_rd0", rd_b[31:0], 32'hA5A5A5A5);
    chk("nb_new_rd1", rd_b[63:32], 32'hA5A5A5A5);

    // Stall hold and refresh
    wr(5'd4, 32'h44); tick();
    wr(5'd3, 32'h10); tick();
    wr_en = 1'b0; rd_addr[4:0] = 5'd3; tick();
    chk("cap_r3", rd_a[31:0], 32'h10);
    stall = 1'b1; rd_addr[4:0] = 5'd4; tick();
    chk("stall1", rd_a[31:0], 32'h10);
    wr(5'd3, 32'h20); tick();
    chk("stall2_refresh", rd_a[31:0], 32'h20);
    chk("stall2_nb_hold", rd_b[31:0], 32'h10);
    wr_en = 1'b0; tick();
    chk("stall3_hold", rd_a[31:0], 32'h20);
    stall = 1'b0; tick();
    chk("release_r4", rd_a[31:0], 32'h44);

    // Flush beats stall
    wr(5'd9, 32'h55); tick();
    wr_en = 1'b0; rd_addr = {5'd9, 5'd9}; stall = 1'b1; flush = 1'b1; tick();
    chk("flush_rd0", rd_a[31:0], 32'h0);
    chk("flush_rd1", rd_a[63:32], 32'h0);
    flush = 1'b0; wr(5'd0, 32'hFFFFFFFF); tick();
    chk("post_flush_r0", rd_a[31:0], 32'h0);
    chk("post_flush_nz_refresh", rd_z[31:0], 32'hFFFFFFFF);
    stall = 1'b0; wr_en = 1'b0;

    // Reset mid-stall, then debug sweep
    wr(5'd6, 32'h77); tick();
    wr_en = 1'b0; rd_addr[4:0] = 5'd6; tick();
    chk("cap_r6", rd_a[31:0], 32'h77);
    stall = 1'b1; tick();
    chk("stall_r6", rd_a[31:0], 32'h77);
    rst_n = 1'b0; tick();
    chk("rst_mid_stall", rd_a[31:0], 32'h0);
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      dbg_addr = a[4:0]; tick();
      chk($sformatf("sweep_dbg_%0d", a), dbg_a, 32'h0);
      chk($sformatf("sweep_nz_dbg_%0d", a), dbg_z, 32'h0);
    end
    chk("stall_after_rst", rd_a[31:0], 32'h0);
    stall = 1'b0; tick();
    chk("resume_r6_cleared", rd_a[31:0], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
